image_fetch_core: RTL and testbench
===================================

Name: image_fetch_core

Overview:
- Image-fetch front end of the Sobel pipeline: one block containing the top-level run controller FSM, the memory controller and a single-port 8-bit image BRAM (MAX_ROW*MAX_COL bytes).
- On start, streams every stored pixel once, in raster order, to the downstream edge-detection core as data/enable beats.
- Then waits for that core to report completion.
- Includes a host load port so image contents can be written while idle.

Parameters:
- MAX_ROW, 540, image rows.
- MAX_COL, 540, image columns.
- ADDR_W, 19, BRAM address width; must satisfy 2^ADDR_W >= MAX_ROW*MAX_COL.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start_i  in  1  start request, level-sensitive.
- ld_en_i  in  1  host write strobe; honoured only in IDLE.
- ld_addr_i  in  ADDR_W  host write address.
- ld_data_i  in  DATA_W  host write data.
- data_o  out  DATA_W  streamed pixel.
- data_en_o  out  1  data_o valid this cycle.
- core_run_o  out  1  downstream core enabled.
- core_done_i  in  1  downstream core finished.
- fetch_run_o  out  1  fetch in progress (debug/observe).
- fetch_done_o  out  1  one-cycle pulse, fetch finished.
- state_o  out  3  current controller state.
- state_n_o  out  3  next controller state (combinational).
- cnt_img_row_o  out  10  row index of the current data_o beat.
- cnt_img_col_o  out  10  column index of the current data_o beat.

Behaviour:
- Reset state: state=IDLE, all counters 0. data_o=0, data_en_o=0, fetch_done_o=0, core_run_o=0, fetch_run_o=0. BRAM read register is cleared; BRAM array contents are not cleared.
- Controller states: IDLE=0, FETCH=1, CORE=2, DONE=3.
  - IDLE: go to FETCH when start_i=1.
  - FETCH: go to CORE when fetch_done_o=1.
  - CORE: go to DONE when core_done_i=1.
  - DONE: go to IDLE when start_i=0. A held-high start therefore runs exactly once.
  - Codes 4-7 return to IDLE.
- Outputs decoded from the registered state:
  - fetch_run_o=1 only in FETCH.
  - core_run_o=1 in FETCH and CORE, so the core consumes the stream live.
- BRAM: single port; one read or one write per cycle.
  - Synchronous read, 1-cycle latency, no output register.
  - Write-first on a write cycle.
- Memory controller, with N=MAX_ROW*MAX_COL:
  - While fetch_run_o=1 and addr_cnt<N: BRAM enabled for read at addr_cnt, and addr_cnt increments each cycle.
  - data_en_o is the read-enable delayed by exactly 1 cycle; data_o is the BRAM read data in that cycle.
  - Yields N consecutive beats, with no gaps, ending at address N-1.
- Latency: if state becomes FETCH in cycle c, beats occur in cycles c+1..c+N. fetch_done_o pulses in c+N+1. state_o=CORE from c+N+2.
- Row/column counters: advance after each beat; col wraps at MAX_COL-1 to 0 and increments row. The final beat shows row=MAX_ROW-1, col=MAX_COL-1.
- addr_cnt and the row/col counters clear to 0 whenever fetch_run_o=0, so every run restarts at address 0.
- Host load:
  - In IDLE with ld_en_i=1, write ld_data_i to ld_addr_i.
  - Ignored in other states, including when start_i and ld_en_i are both high in the same IDLE cycle.
  - Addresses >= N are ignored.
- core_done_i outside CORE has no effect.
- Asynchronous reset mid-run immediately returns everything to the reset values; BRAM contents are retained.

Test Plan:
- Reset with start_i held 1 (MAX_ROW=MAX_COL=4) → during reset all outputs 0 and state_o=0. After release: state_o=1 on the first clock, then 16 beats.
- Load addr k with value k+8'h10 (k=0..15), then start → data_o sequence 8'h10..8'h1F on consecutive data_en_o cycles. (row,col) goes (0,0),(0,1)..(3,3). fetch_done_o pulses 1 cycle after the last beat.
- After the fetch, hold core_done_i=0 for 5 cycles → state_o stays 2 and core_run_o stays 1. Pulse core_done_i → state_o=3, core_run_o=0.
- In DONE with start_i still 1 → no second fetch. Drop start_i → state_o=0. Raise start_i → new fetch beginning at address 0.
- Assert ld_en_i during FETCH → memory unchanged, verified by a later run's data.
- Assert rst_n=0 at beat 7 → data_en_o=0 and state_o=0 immediately. Restart → full 16-beat sequence from address 0 with the loaded data intact.

Source files
------------

// File: rtl/image_fetch_core_if.sv
// Host load port and pixel stream to the edge-detection core.
interface image_fetch_core_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              ld_en_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;
  logic [DATA_W-1:0] data_o;
  logic              data_en_o;
  logic              core_run_o;
  logic              core_done_i;

  modport slave (
    input  ld_en_i, ld_addr_i, ld_data_i, core_done_i,
    output data_o, data_en_o, core_run_o
  );

  modport master (
    output ld_en_i, ld_addr_i, ld_data_i, core_done_i,
    input  data_o, data_en_o, core_run_o
  );
endinterface

// File: rtl/image_fetch_core.sv
// Sobel front end: run controller, memory controller and single-port image BRAM.
// Streams the stored image once in raster order, then waits for the core to finish.
module image_fetch_core #(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  image_fetch_core_if.slave   bus,
  output logic                fetch_run_o,
  output logic                fetch_done_o,
  output logic [2:0]          state_o,
  output logic [2:0]          state_n_o,
  output logic [9:0]          cnt_img_row_o,
  output logic [9:0]          cnt_img_col_o
);

  localparam int unsigned     N        = MAX_ROW * MAX_COL;
  localparam int unsigned     IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W:0] N_CNT    = (ADDR_W+1)'(N);
  localparam logic [9:0]      LAST_ROW = 10'(MAX_ROW - 1);
  localparam logic [9:0]      LAST_COL = 10'(MAX_COL - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CORE  = 3'd2,
    DONE  = 3'd3
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   addr_cnt;
  logic [9:0]        row, col;
  logic              rd_en, wr_en, data_en, fetch_done;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i)          state_n = FETCH;
      FETCH:   if (fetch_done)       state_n = CORE;
      CORE:    if (bus.core_done_i)  state_n = DONE;
      DONE:    if (!start_i)         state_n = IDLE;
      default:                       state_n = IDLE;
    endcase
  end

  assign fetch_run_o    = (state == FETCH);
  assign bus.core_run_o = (state == FETCH) || (state == CORE);

  // Reads and host writes never coincide: writes are only taken in IDLE.
  assign rd_en   = fetch_run_o && (addr_cnt < N_CNT);
  assign wr_en   = (state == IDLE) && !start_i && bus.ld_en_i &&
                   ({1'b0, bus.ld_addr_i} < N_CNT);
  assign mem_idx = wr_en ? bus.ld_addr_i[IDX_W-1:0] : addr_cnt[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[mem_idx] <= bus.ld_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      data_en <= 1'b0;
    end else begin
      data_en <= rd_en;
      if (wr_en)      rd_data <= bus.ld_data_i;
      else if (rd_en) rd_data <= mem[mem_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt   <= '0;
      row        <= '0;
      col        <= '0;
      fetch_done <= 1'b0;
    end else if (!fetch_run_o) begin
      addr_cnt   <= '0;
      row        <= '0;
      col        <= '0;
      fetch_done <= 1'b0;
    end else begin
      if (rd_en) addr_cnt <= addr_cnt + (ADDR_W+1)'(1);
      // Address reaches N in the cycle of the last beat; pulse exactly once after it.
      fetch_done <= (addr_cnt == N_CNT) && !fetch_done;
      if (data_en) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

  assign bus.data_o    = rd_data;
  assign bus.data_en_o = data_en;
  assign fetch_done_o  = fetch_done;
  assign state_o       = state;
  assign state_n_o     = state_n;
  assign cnt_img_row_o = row;
  assign cnt_img_col_o = col;

endmodule

// File: tb/tb_image_fetch_core.sv
// Bench for image_fetch_core on a 4x4 image: schedule-level model plus directed scenarios.
module tb_image_fetch_core;
  localparam int MAX_ROW = 4;
  localparam int MAX_COL = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int N       = MAX_ROW * MAX_COL;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       fetch_run, fetch_done;
  logic [2:0] state, state_n;
  logic [9:0] row, col;

  image_fetch_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  image_fetch_core #(
    .MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bus),
    .fetch_run_o(fetch_run), .fetch_done_o(fetch_done),
    .state_o(state), .state_n_o(state_n),
    .cnt_img_row_o(row), .cnt_img_col_o(col)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Model: controller state, cycles spent in FETCH, and what the image memory holds.
  int         m_state = 0;
  int         fc      = 0;
  logic [7:0] m_mem   [N];
  bit         m_valid [N];

  function automatic int next_st(input int st, input logic s, input logic cd, input int f);
    case (st)
      0:       return s ? 1 : 0;
      1:       return (f == N + 1) ? 2 : 1;
      2:       return cd ? 3 : 2;
      3:       return s ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      fc      <= 0;
    end else begin
      m_state <= next_st(m_state, start, bus.core_done_i, fc);
      fc      <= (m_state == 1) ? fc + 1 : 0;
      if (m_state == 0 && !start && bus.ld_en_i && int'(bus.ld_addr_i) < N) begin
        m_mem[bus.ld_addr_i[3:0]]   <= bus.ld_data_i;
        m_valid[bus.ld_addr_i[3:0]] <= 1'b1;
      end
    end
  end

  logic [7:0] beats [$];
  int         last_row = -1, last_col = -1, last_beat_cyc = -1, done_cyc = -1;

  always @(negedge clk) begin : compare
    logic exp_en;
    int   k;
    if (!rst_n) begin
      check("rst_state", state, 0);
      check("rst_data_en", bus.data_en_o, 0);
      check("rst_data", bus.data_o, 0);
      check("rst_core_run", bus.core_run_o, 0);
      check("rst_fetch_run", fetch_run, 0);
      check("rst_fetch_done", fetch_done, 0);
    end else begin
      exp_en = (m_state == 1) && (fc >= 1) && (fc <= N);
      check("state", state, m_state);
      check("state_n", state_n, next_st(m_state, start, bus.core_done_i, fc));
      check("fetch_run", fetch_run, m_state == 1);
      check("core_run", bus.core_run_o, (m_state == 1) || (m_state == 2));
      check("fetch_done", fetch_done, (m_state == 1) && (fc == N + 1));
      check("data_en", bus.data_en_o, exp_en);
      if (exp_en && bus.data_en_o) begin
        k = fc - 1;
        check("beat_row", row, k / MAX_COL);
        check("beat_col", col, k % MAX_COL);
        if (m_valid[k]) check("beat_data", bus.data_o, m_mem[k]);
      end
      if (m_state == 0) begin
        check("idle_row", row, 0);
        check("idle_col", col, 0);
      end
    end
    if (bus.data_en_o) begin
      beats.push_back(bus.data_o);
      last_row      = row;
      last_col      = col;
      last_beat_cyc = cyc;
    end
    if (fetch_done) done_cyc = cyc;
  end

  task automatic wait_state(input int target, input int max_cyc, input string name);
    int n = 0;
    while (state !== 3'(target) && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, state, target);
  endtask

  task automatic finish_core();
    @(posedge clk); #1 bus.core_done_i = 1'b1;
    @(posedge clk); #1 bus.core_done_i = 1'b0;
  endtask

  initial begin
    int n;
    bus.ld_en_i = 1'b0; bus.ld_addr_i = '0; bus.ld_data_i = '0; bus.core_done_i = 1'b0;
    start = 1'b1;
    rst_n = 1'b0;

    // Reset with start held high.
    repeat (3) @(negedge clk);
    #1;
    check("lit_rst_state", state, 0);
    check("lit_rst_data_en", bus.data_en_o, 0);
    check("lit_rst_core_run", bus.core_run_o, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    check("lit_first_clk_state", state, 1);
    wait_state(2, 40, "boot_reach_core");
    check("lit_boot_beats", beats.size(), 16);
    finish_core();
    @(posedge clk); #1 start = 1'b0;
    wait_state(0, 10, "boot_back_idle");

    // Load k -> k+0x10, one out-of-range write, then a write that coincides with start.
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      bus.ld_en_i = 1'b1; bus.ld_addr_i = 5'(k); bus.ld_data_i = 8'(k + 16);
    end
    @(posedge clk); #1 bus.ld_addr_i = 5'd20; bus.ld_data_i = 8'hAA;
    @(negedge clk); #1 beats.delete();
    @(posedge clk); #1 bus.ld_addr_i = 5'd0; bus.ld_data_i = 8'hEE; start = 1'b1;
    @(posedge clk); #1 bus.ld_addr_i = 5'd3; bus.ld_data_i = 8'h55;
    repeat (3) @(posedge clk);
    #1 bus.ld_en_i = 1'b0;
    wait_state(2, 40, "run1_reach_core");
    check("lit_run1_count", beats.size(), 16);
    check("lit_run1_first", beats[0], 8'h10);
    check("lit_run1_addr4", beats[4], 8'h14);
    check("lit_run1_last", beats[15], 8'h1F);
    check("lit_run1_last_row", last_row, 3);
    check("lit_run1_last_col", last_col, 3);
    check("lit_done_after_last", done_cyc - last_beat_cyc, 1);

    // Core holds off, then finishes.
    repeat (5) begin
      @(negedge clk); #1;
      check("lit_core_hold_state", state, 2);
      check("lit_core_hold_run", bus.core_run_o, 1);
    end
    finish_core();
    @(negedge clk); #1;
    check("lit_done_state", state, 3);
    check("lit_done_core_run", bus.core_run_o, 0);

    // Held start must not retrigger; dropping it returns to IDLE.
    beats.delete();
    repeat (6) begin
      @(negedge clk); #1;
      check("lit_done_hold", state, 3);
    end
    check("lit_no_refetch", beats.size(), 0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("lit_idle_again", state, 0);

    // Second run: the write attempted during FETCH must not have landed.
    beats.delete();
    @(posedge clk); #1 start = 1'b1;
    wait_state(2, 40, "run2_reach_core");
    check("lit_run2_count", beats.size(), 16);
    check("lit_run2_first", beats[0], 8'h10);
    check("lit_run2_addr3", beats[3], 8'h13);
    finish_core();
    @(posedge clk); #1 start = 1'b0;
    wait_state(0, 10, "run2_back_idle");

    // Asynchronous reset at beat 7, then a full rerun.
    beats.delete();
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    while (beats.size() < 8 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check("lit_reached_beat7", beats.size(), 8);
    #1 rst_n = 1'b0;
    #1;
    check("lit_async_data_en", bus.data_en_o, 0);
    check("lit_async_state", state, 0);
    check("lit_async_core_run", bus.core_run_o, 0);
    repeat (2) @(negedge clk);
    beats.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    wait_state(2, 40, "rerun_reach_core");
    check("lit_rerun_count", beats.size(), 16);
    for (int k = 0; k < N; k++) begin
      if (k < beats.size()) check("lit_rerun_beat", beats[k], k + 16);
    end
    finish_core();
    @(posedge clk); #1 start = 1'b0;
    wait_state(0, 10, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
